// File: rtl/uart_hex_sender_pkg.sv
// Shared definitions for the UART text blocks: ASCII constants and hex-sender FSM states.
// The optional "0x" prefix is enabled by defining UART_HEX_SENDER_PREFIX_EN.
package uart_hex_sender_pkg;

    localparam int unsigned BYTE_W = 8;

    localparam logic [BYTE_W-1:0] ASC_0     = 8'h30;
    localparam logic [BYTE_W-1:0] ASC_A_M10 = 8'h37;
    localparam logic [BYTE_W-1:0] ASC_CR    = 8'h0D;
    localparam logic [BYTE_W-1:0] ASC_LF    = 8'h0A;
`ifdef UART_HEX_SENDER_PREFIX_EN
    localparam logic [BYTE_W-1:0] ASC_X     = 8'h78;
`endif

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
`ifdef UART_HEX_SENDER_PREFIX_EN
        ST_PFX0  = 3'd1,
        ST_PFX1  = 3'd2,
`endif
        ST_DIGIT = 3'd3,
        ST_CR    = 3'd4,
        ST_LF    = 3'd5
    } state_e;

endpackage

// File: rtl/uart_hex_sender_hex_ascii.sv
// Combinational nibble to uppercase ASCII hex digit ('0'-'9', 'A'-'F').
module hex_ascii
    import uart_hex_sender_pkg::*;
(
    input  logic [3:0]        nib_i,
    output logic [BYTE_W-1:0] ascii_o
);

    // Digits map onto '0'.., letters onto 'A'.. via the 'A'-10 offset
    always_comb begin
        if (nib_i < 4'd10) begin
            ascii_o = ASC_0 + {4'h0, nib_i};
        end else begin
            ascii_o = ASC_A_M10 + {4'h0, nib_i};
        end
    end

endmodule

// File: rtl/uart_hex_sender.sv
// Prints a binary word as uppercase ASCII hex (MSB nibble first, optional CR LF) into uart_tx.
// Define UART_HEX_SENDER_PREFIX_EN to emit a "0x" prefix before the digits.
module uart_hex_sender
    import uart_hex_sender_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned NEWLINE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             word_valid,
    input  logic [WIDTH-1:0] word_in,
    output logic             word_ready,
    output logic             tx_en,
    output logic [7:0]       tx_data,
    input  logic             tx_rdy
);

    localparam int unsigned N     = WIDTH / 4;
    localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic [CNT_W-1:0]   nib_cnt_q, nib_cnt_d;
    logic               tx_en_q, tx_en_d;
    logic [BYTE_W-1:0]  tx_data_q, tx_data_d;
    logic               accept_c;
    logic               byte_done_c;
    logic [3:0]         digit_nib_c;
    logic [BYTE_W-1:0]  digit_ascii_c;

    assign word_ready  = (state_q == ST_IDLE) && !rst;
    assign accept_c    = word_valid && word_ready;
    assign byte_done_c = tx_en_q && tx_rdy;
    assign tx_en       = tx_en_q;
    assign tx_data     = tx_data_q;

    // Digit for the byte that will be on tx_data next cycle
    assign digit_nib_c = shreg_d[WIDTH-1 -: 4];

    hex_ascii u_hex_ascii (
        .nib_i   (digit_nib_c),
        .ascii_o (digit_ascii_c)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and output registers; reset discards any half-printed word
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg_q   <= '0;
            nib_cnt_q <= '0;
            tx_en_q   <= 1'b0;
            tx_data_q <= 8'h00;
        end else begin
            shreg_q   <= shreg_d;
            nib_cnt_q <= nib_cnt_d;
            tx_en_q   <= tx_en_d;
            tx_data_q <= tx_data_d;
        end
    end

    // Next state: advance one byte per uart_tx handshake
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        nib_cnt_d = nib_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    shreg_d   = word_in;
                    nib_cnt_d = CNT_W'(N - 1);
`ifdef UART_HEX_SENDER_PREFIX_EN
                    state_d   = ST_PFX0;
`else
                    state_d   = ST_DIGIT;
`endif
                end
            end
`ifdef UART_HEX_SENDER_PREFIX_EN
            ST_PFX0: begin
                if (byte_done_c) state_d = ST_PFX1;
            end
            ST_PFX1: begin
                if (byte_done_c) state_d = ST_DIGIT;
            end
`endif
            ST_DIGIT: begin
                if (byte_done_c) begin
                    shreg_d = shreg_q << 4;
                    if (nib_cnt_q == '0) begin
                        state_d = (NEWLINE != 0) ? ST_CR : ST_IDLE;
                    end else begin
                        nib_cnt_d = nib_cnt_q - CNT_W'(1);
                    end
                end
            end
            ST_CR: begin
                if (byte_done_c) state_d = ST_LF;
            end
            ST_LF: begin
                if (byte_done_c) state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output: byte offered in the upcoming state, so there is no gap between bytes
    always_comb begin
        tx_en_d   = 1'b0;
        tx_data_d = 8'h00;
        case (state_d)
`ifdef UART_HEX_SENDER_PREFIX_EN
            ST_PFX0: begin
                tx_en_d   = 1'b1;
                tx_data_d = ASC_0;
            end
            ST_PFX1: begin
                tx_en_d   = 1'b1;
                tx_data_d = ASC_X;
            end
`endif
            ST_DIGIT: begin
                tx_en_d   = 1'b1;
                tx_data_d = digit_ascii_c;
            end
            ST_CR: begin
                tx_en_d   = 1'b1;
                tx_data_d = ASC_CR;
            end
            ST_LF: begin
                tx_en_d   = 1'b1;
                tx_data_d = ASC_LF;
            end
            default: begin
                tx_en_d   = 1'b0;
                tx_data_d = 8'h00;
            end
        endcase
    end

endmodule
